// File: rtl/nway_sa_cache.sv
// nway_sa_cache: N-way set-associative cache with one word per line,
// write-back / write-allocate, dirty-victim eviction and a blocking refill.
// Optional macro PLRU_EN selects tree pseudo-LRU replacement. Without it,
// each set uses a round-robin pointer that advances on every install.
module nway_sa_cache #(
  parameter int WAYS     = 4,
  parameter int TAG_W    = 18,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 6,
  parameter int DATA_W   = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_req,
  output logic                                 o_ready,
  input  logic                                 memRW,
  input  logic [TAG_W-1:0]                     i_tag,
  input  logic [INDEX_W-1:0]                   i_index,
  input  logic [OFFSET_W-1:0]                  i_offset,
  input  logic [DATA_W-1:0]                    dataW,
  output logic                                 o_valid,
  output logic [DATA_W-1:0]                    o_data,
  output logic                                 o_hit,
  output logic                                 cache_miss,
  output logic                                 o_mem_req,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0]    o_mem_addr,
  input  logic                                 i_memory_response,
  input  logic [DATA_W-1:0]                    i_memory_line,
  output logic                                 o_evict,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0]    o_evict_addr,
  output logic [DATA_W-1:0]                    o_evict_data
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EVICT  = 2'd2,
    ST_REFILL = 2'd3
  } state_t;

  state_t               state_q;
  logic [TAG_W-1:0]     tag_q;
  logic [INDEX_W-1:0]   idx_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 rw_q;
  logic [WAY_W-1:0]     victim_q;

  // Line storage: tags and data are not reset; valid/dirty guard them.
  logic [TAG_W-1:0]     tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0]    data_mem [SETS][WAYS];
  logic [WAYS-1:0]      valid_q  [SETS];
  logic [WAYS-1:0]      dirty_q  [SETS];

`ifdef PLRU_EN
  logic [WAYS-2:0]      plru_q   [SETS];

  // Tree walk from the root; level l decides victim bit l (LSB first).
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_W-1:0] way;
    int node;
    way  = '0;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      way[l] = bits[node-1];
      node   = 2 * node + (way[l] ? 1 : 0);
    end
    return way;
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] nb;
    int node;
    nb   = bits;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      nb[node-1] = ~way[l];
      node       = 2 * node + (way[l] ? 1 : 0);
    end
    return nb;
  endfunction
`else
  logic [WAY_W-1:0]     rr_q     [SETS];
`endif

  logic [WAYS-1:0]      set_valid_s;
  logic [WAYS-1:0]      set_dirty_s;
  logic [WAYS-1:0]      hit_vec_s;
  logic                 hit_s;
  logic [WAY_W-1:0]     hit_way_s;
  logic [WAY_W-1:0]     inv_way_s;
  logic [WAY_W-1:0]     repl_way_s;
  logic [WAY_W-1:0]     victim_s;
  logic                 hit_wr_s;
  logic                 install_s;
  logic                 unused_s;

  // The byte offset does not select anything with one word per line.
  assign unused_s = ^i_offset;

  // Tag compare across the indexed set and victim selection.
  always_comb begin
    set_valid_s = valid_q[idx_q];
    set_dirty_s = dirty_q[idx_q];
    hit_vec_s   = '0;
    hit_way_s   = '0;
    inv_way_s   = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w] = set_valid_s[w] && (tag_mem[idx_q][w] == tag_q);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way_s = hit_vec_s[w]    ? WAY_W'(w) : hit_way_s;
      inv_way_s = !set_valid_s[w] ? WAY_W'(w) : inv_way_s;
    end
    hit_s = |hit_vec_s;
`ifdef PLRU_EN
    repl_way_s = plru_victim(plru_q[idx_q]);
`else
    repl_way_s = rr_q[idx_q];
`endif
    victim_s  = (&set_valid_s) ? repl_way_s : inv_way_s;
    hit_wr_s  = (state_q == ST_LOOKUP) && hit_s && rw_q;
    install_s = (state_q == ST_REFILL) && i_memory_response;
  end

  // Tag/data array writes: write hits and refill installs.
  always_ff @(posedge clk) begin
    if (hit_wr_s) begin
      data_mem[idx_q][hit_way_s] <= wdata_q;
    end else if (install_s) begin
      tag_mem[idx_q][victim_q]  <= tag_q;
      data_mem[idx_q][victim_q] <= rw_q ? wdata_q : i_memory_line;
    end
  end

  // Controller FSM with registered outputs and per-set valid/dirty/replacement state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
      victim_q     <= '0;
      o_ready      <= 1'b1;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_hit        <= 1'b0;
      cache_miss   <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_addr   <= '0;
      o_evict      <= 1'b0;
      o_evict_addr <= '0;
      o_evict_data <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
`ifdef PLRU_EN
        plru_q[s]  <= '0;
`else
        rr_q[s]    <= '0;
`endif
      end
    end else begin
      o_valid    <= 1'b0;
      cache_miss <= 1'b0;
      o_evict    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_req) begin
            tag_q   <= i_tag;
            idx_q   <= i_index;
            wdata_q <= dataW;
            rw_q    <= memRW;
            o_ready <= 1'b0;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit_s) begin
            o_valid <= 1'b1;
            o_hit   <= 1'b1;
            o_data  <= rw_q ? wdata_q : data_mem[idx_q][hit_way_s];
            if (rw_q) begin
              dirty_q[idx_q][hit_way_s] <= 1'b1;
            end
`ifdef PLRU_EN
            plru_q[idx_q] <= plru_touch(plru_q[idx_q], hit_way_s);
`endif
            o_ready <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cache_miss <= 1'b1;
            victim_q   <= victim_s;
            o_mem_addr <= {tag_q, idx_q, {OFFSET_W{1'b0}}};
            if (set_valid_s[victim_s] && set_dirty_s[victim_s]) begin
              o_evict      <= 1'b1;
              o_evict_addr <= {tag_mem[idx_q][victim_s], idx_q, {OFFSET_W{1'b0}}};
              o_evict_data <= data_mem[idx_q][victim_s];
              state_q      <= ST_EVICT;
            end else begin
              o_mem_req <= 1'b1;
              state_q   <= ST_REFILL;
            end
          end
        end
        ST_EVICT: begin
          o_mem_req <= 1'b1;
          state_q   <= ST_REFILL;
        end
        ST_REFILL: begin
          if (i_memory_response) begin
            valid_q[idx_q][victim_q] <= 1'b1;
            dirty_q[idx_q][victim_q] <= rw_q;
`ifdef PLRU_EN
            plru_q[idx_q] <= plru_touch(plru_q[idx_q], victim_q);
`else
            rr_q[idx_q]   <= rr_q[idx_q] + {{(WAY_W-1){1'b0}}, 1'b1};
`endif
            o_valid   <= 1'b1;
            o_hit     <= 1'b0;
            o_data    <= rw_q ? wdata_q : i_memory_line;
            o_mem_req <= 1'b0;
            o_ready   <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          o_mem_req <= 1'b0;
          o_ready   <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nway_sa_cache.sv
// Directed self-checking bench for nway_sa_cache (default parameters).
module tb_nway_sa_cache;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic        o_ready;
  logic        memRW;
  logic [17:0] i_tag;
  logic [7:0]  i_index;
  logic [5:0]  i_offset;
  logic [31:0] dataW;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_hit;
  logic        cache_miss;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_memory_response;
  logic [31:0] i_memory_line;
  logic        o_evict;
  logic [31:0] o_evict_addr;
  logic [31:0] o_evict_data;

  int checks;
  int errors;

  // Results of the last transaction.
  int          r_miss;
  int          r_evicts;
  logic [31:0] r_evaddr;
  logic [31:0] r_evdata;
  logic        r_memreq;
  logic [31:0] r_memaddr;
  logic        r_valid;
  int          r_lat;
  logic        r_hit;
  logic [31:0] r_data;

  nway_sa_cache dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_ready(o_ready), .memRW(memRW),
    .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset), .dataW(dataW),
    .o_valid(o_valid), .o_data(o_data), .o_hit(o_hit), .cache_miss(cache_miss),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_memory_response(i_memory_response), .i_memory_line(i_memory_line),
    .o_evict(o_evict), .o_evict_addr(o_evict_addr), .o_evict_data(o_evict_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request and act as memory; sample every negedge up to o_valid.
  task automatic do_req(input logic rw, input logic [17:0] tag, input logic [7:0] idx,
                        input logic [31:0] wd, input logic [31:0] line);
    r_miss = 0; r_evicts = 0; r_evaddr = '0; r_evdata = '0;
    r_memreq = 1'b0; r_memaddr = '0; r_valid = 1'b0; r_lat = 0;
    r_hit = 1'b0; r_data = '0;
    @(negedge clk);
    i_req = 1'b1; memRW = rw; i_tag = tag; i_index = idx; i_offset = 6'h15; dataW = wd;
    @(posedge clk);
    @(negedge clk);
    i_req = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      i_memory_response = 1'b0;
      if (cache_miss) r_miss++;
      if (o_evict) begin
        r_evicts++;
        r_evaddr = o_evict_addr;
        r_evdata = o_evict_data;
      end
      if (o_mem_req) begin
        r_memreq = 1'b1;
        r_memaddr = o_mem_addr;
        i_memory_response = 1'b1;
        i_memory_line = line;
      end
      if (o_valid) begin
        r_valid = 1'b1;
        r_lat = k;
        r_hit = o_hit;
        r_data = o_data;
        break;
      end
      @(negedge clk);
    end
    i_memory_response = 1'b0;
  endtask

  initial begin
    int evsum;
    int seen;
    checks = 0; errors = 0;
    rst = 1'b1; i_req = 1'b0; memRW = 1'b0; i_tag = '0; i_index = '0; i_offset = '0;
    dataW = '0; i_memory_response = 1'b0; i_memory_line = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_miss", 64'(cache_miss), 64'd0);
    check("rst_memreq", 64'(o_mem_req), 64'd0);
    check("rst_evict", 64'(o_evict), 64'd0);
    check("rst_hit", 64'(o_hit), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_maddr", 64'(o_mem_addr), 64'd0);

    // Cold read miss: tag 1 index 3 -> addr 0x40C0
    do_req(1'b0, 18'd1, 8'd3, 32'h0, 32'hA5A5A5A5);
    check("m1_valid", 64'(r_valid), 64'd1);
    check("m1_miss", 64'(r_miss), 64'd1);
    check("m1_memreq", 64'(r_memreq), 64'd1);
    check("m1_maddr", 64'(r_memaddr), 64'h40C0);
    check("m1_hit", 64'(r_hit), 64'd0);
    check("m1_data", 64'(r_data), 64'hA5A5A5A5);
    check("m1_lat", 64'(r_lat), 64'd3);

    // Repeat read hits two cycles after acceptance
    do_req(1'b0, 18'd1, 8'd3, 32'h0, 32'hDEADBEEF);
    check("h1_valid", 64'(r_valid), 64'd1);
    check("h1_hit", 64'(r_hit), 64'd1);
    check("h1_data", 64'(r_data), 64'hA5A5A5A5);
    check("h1_lat", 64'(r_lat), 64'd2);
    check("h1_memreq", 64'(r_memreq), 64'd0);
    check("h1_miss", 64'(r_miss), 64'd0);
    repeat (3) @(negedge clk);
    check("hold_valid", 64'(o_valid), 64'd0);
    check("hold_data", 64'(o_data), 64'hA5A5A5A5);
    check("hold_hit", 64'(o_hit), 64'd1);

    // Write hit, then fill set 3 so the dirty line is evicted
    do_req(1'b1, 18'd1, 8'd3, 32'h12345678, 32'h0);
    check("wh_hit", 64'(r_hit), 64'd1);
    check("wh_data", 64'(r_data), 64'h12345678);
    check("wh_lat", 64'(r_lat), 64'd2);
    evsum = 0;
    for (int t = 2; t <= 4; t++) begin
      do_req(1'b0, 18'(t), 8'd3, 32'h0, 32'h11111111 * t);
      evsum += r_evicts;
      check("fill_data", 64'(r_data), 64'(32'h11111111 * t));
    end
    check("fill_noev", 64'(evsum), 64'd0);
    do_req(1'b0, 18'd5, 8'd3, 32'h0, 32'h55555555);
    check("ev_count", 64'(r_evicts), 64'd1);
    check("ev_addr", 64'(r_evaddr), 64'h40C0);
    check("ev_data", 64'(r_evdata), 64'h12345678);
    check("ev_lat", 64'(r_lat), 64'd4);
    check("ev_rdata", 64'(r_data), 64'h55555555);
    check("ev_hit", 64'(r_hit), 64'd0);

    // Replacement order in set 0
    for (int t = 1; t <= 4; t++) begin
      do_req(1'b0, 18'(t), 8'd0, 32'h0, 32'h100 + 32'(t));
      check("s0_fill_miss", 64'(r_miss), 64'd1);
    end
    do_req(1'b0, 18'd1, 8'd0, 32'h0, 32'h0);
    check("s0_hit1", 64'(r_hit), 64'd1);
    check("s0_hit1_data", 64'(r_data), 64'h101);
    do_req(1'b0, 18'd5, 8'd0, 32'h0, 32'h105);
    check("s0_t5_miss", 64'(r_miss), 64'd1);
    check("s0_t5_noev", 64'(r_evicts), 64'd0);
`ifdef PLRU_EN
    do_req(1'b0, 18'd1, 8'd0, 32'h0, 32'h0);
    check("plru_keep1", 64'(r_hit), 64'd1);
    do_req(1'b0, 18'd2, 8'd0, 32'h0, 32'h102);
    check("plru_vict2", 64'(r_miss), 64'd1);
`else
    do_req(1'b0, 18'd2, 8'd0, 32'h0, 32'h0);
    check("rr_keep2", 64'(r_hit), 64'd1);
    check("rr_keep2_d", 64'(r_data), 64'h102);
    do_req(1'b0, 18'd1, 8'd0, 32'h0, 32'h101);
    check("rr_vict1", 64'(r_miss), 64'd1);
`endif

    // Reset in the middle of a refill
    @(negedge clk);
    i_req = 1'b1; memRW = 1'b0; i_tag = 18'd7; i_index = 8'd9; dataW = '0;
    @(posedge clk);
    @(negedge clk);
    i_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      if (o_mem_req) seen = 1;
      else @(negedge clk);
    end
    check("rf_memreq", 64'(seen), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rf_ready", 64'(o_ready), 64'd1);
    check("rf_memreq0", 64'(o_mem_req), 64'd0);
    i_memory_response = 1'b1; i_memory_line = 32'h77777777;
    @(negedge clk);
    i_memory_response = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_valid) seen++;
      @(negedge clk);
    end
    check("rf_novalid", 64'(seen), 64'd0);
    do_req(1'b0, 18'd7, 8'd9, 32'h0, 32'h77777777);
    check("rf_remiss", 64'(r_miss), 64'd1);
    check("rf_rehit", 64'(r_hit), 64'd0);
    check("rf_redata", 64'(r_data), 64'h77777777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
